// File: rtl/minn_peak_detector.sv
// Minn timing peak detector: qualifies metric against thr*energy/256, tracks the running
// maximum and reports its sample index once it has held for HOLD_LEN samples.
module minn_peak_detector #(
    parameter int unsigned SUM_WIDTH = 34,
    parameter int unsigned IDX_WIDTH = 16,
    parameter int unsigned HOLD_LEN  = 256,
    parameter int unsigned GAP_LEN   = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic signed [SUM_WIDTH-1:0] in_metric,
    input  logic signed [SUM_WIDTH-1:0] in_energy,
    input  logic [7:0]                  thr,
    output logic                        det_valid,
    output logic [IDX_WIDTH-1:0]        det_index,
    output logic signed [SUM_WIDTH-1:0] det_metric,
    output logic                        busy
);

    localparam int unsigned PW = SUM_WIDTH + 9;
    localparam int unsigned HW = $clog2(HOLD_LEN + 1);
    localparam int unsigned GW = $clog2(GAP_LEN + 1);

    typedef enum logic [1:0] {StSearch, StTrack, StGap} state_t;

    state_t                        state_q, state_d;
    logic [IDX_WIDTH-1:0]          cnt_q;
    logic [HW-1:0]                 hold_q, hold_d;
    logic [GW-1:0]                 gap_q, gap_d;
    logic signed [SUM_WIDTH-1:0]   peak_q, peak_d;
    logic [IDX_WIDTH-1:0]          peak_idx_q, peak_idx_d;
    logic                          fire;
    logic                          det_valid_q;
    logic [IDX_WIDTH-1:0]          det_index_q;
    logic signed [SUM_WIDTH-1:0]   det_metric_q;
    logic                          busy_q;

    // Full-width compare: metric*256 vs energy*thr, no truncation.
    logic signed [PW-1:0] metric_scaled, energy_scaled;
    logic                 metric_pos, crossing, improve;

    assign metric_scaled = {in_metric[SUM_WIDTH-1], in_metric, 8'd0};
    assign energy_scaled = PW'(in_energy) * PW'($signed({1'b0, thr}));
    assign metric_pos    = !in_metric[SUM_WIDTH-1] && (in_metric != '0);
    assign crossing      = metric_pos && (metric_scaled > energy_scaled);
    assign improve       = crossing && (in_metric > peak_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StSearch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            unique case (state_q)
                StSearch: if (crossing) state_d = StTrack;
                StTrack:  if (!improve && hold_q == HW'(HOLD_LEN - 1)) state_d = StGap;
                StGap:    if (gap_q == GW'(GAP_LEN - 1)) state_d = StSearch;
                default:  state_d = StSearch;
            endcase
        end
    end

    always_comb begin
        hold_d     = hold_q;
        gap_d      = gap_q;
        peak_d     = peak_q;
        peak_idx_d = peak_idx_q;
        fire       = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                StSearch: begin
                    if (crossing) begin
                        peak_d     = in_metric;
                        peak_idx_d = cnt_q;
                        hold_d     = '0;
                    end
                end
                StTrack: begin
                    if (improve) begin
                        peak_d     = in_metric;
                        peak_idx_d = cnt_q;
                        hold_d     = '0;
                    end else begin
                        hold_d = hold_q + HW'(1);
                        if (hold_q == HW'(HOLD_LEN - 1)) begin
                            fire  = 1'b1;
                            gap_d = '0;
                        end
                    end
                end
                StGap:   gap_d = gap_q + GW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            hold_q       <= '0;
            gap_q        <= '0;
            peak_q       <= '0;
            peak_idx_q   <= '0;
            det_valid_q  <= 1'b0;
            det_index_q  <= '0;
            det_metric_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            if (in_valid) begin
                cnt_q <= cnt_q + IDX_WIDTH'(1);
            end
            hold_q      <= hold_d;
            gap_q       <= gap_d;
            peak_q      <= peak_d;
            peak_idx_q  <= peak_idx_d;
            det_valid_q <= fire;
            if (fire) begin
                det_index_q  <= peak_idx_q;
                det_metric_q <= peak_q;
            end
            busy_q <= (state_d != StSearch);
        end
    end

    assign det_valid  = det_valid_q;
    assign det_index  = det_index_q;
    assign det_metric = det_metric_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_minn_peak_detector.sv
// Directed bench for minn_peak_detector: two instances share one stimulus stream, one with a
// 16-bit index and one with a 4-bit index to exercise wrap-around.
module tb_minn_peak_detector;

    localparam int SW = 34;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [SW-1:0] in_metric;
    logic signed [SW-1:0] in_energy;
    logic [7:0]           thr;

    logic                 det_valid_a, busy_a;
    logic [15:0]          det_index_a;
    logic signed [SW-1:0] det_metric_a;
    logic                 det_valid_b, busy_b;
    logic [3:0]           det_index_b;
    logic signed [SW-1:0] det_metric_b;

    int n_checks = 0;
    int n_errors = 0;
    int pulses   = 0;
    logic busy_seen;

    minn_peak_detector #(
        .SUM_WIDTH (SW),
        .IDX_WIDTH (16),
        .HOLD_LEN  (4),
        .GAP_LEN   (8)
    ) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_metric  (in_metric),
        .in_energy  (in_energy),
        .thr        (thr),
        .det_valid  (det_valid_a),
        .det_index  (det_index_a),
        .det_metric (det_metric_a),
        .busy       (busy_a)
    );

    minn_peak_detector #(
        .SUM_WIDTH (SW),
        .IDX_WIDTH (4),
        .HOLD_LEN  (4),
        .GAP_LEN   (8)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_metric  (in_metric),
        .in_energy  (in_energy),
        .thr        (thr),
        .det_valid  (det_valid_b),
        .det_index  (det_index_b),
        .det_metric (det_metric_b),
        .busy       (busy_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic signed [SW-1:0] m);
        in_valid  = v;
        in_metric = m;
        @(posedge clk);
        #1;
        if (det_valid_a) pulses++;
        if (busy_a) busy_seen = 1'b1;
    endtask

    task automatic run(input int n, input logic signed [SW-1:0] m);
        repeat (n) step(1'b1, m);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pulses    = 0;
        busy_seen = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_metric = '0;
        in_energy = 1000;
        thr       = 8'd128;
        busy_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_det_valid", det_valid_a, 0);
        check("rst_det_index", det_index_a, 0);
        check("rst_det_metric", det_metric_a, 0);
        check("rst_busy", busy_a, 0);

        // 500 sits exactly on the threshold (500*256 == 1000*128) and must not cross.
        run(50, 500);
        check("sub_busy_seen", busy_seen, 0);
        run(10, -2000);
        check("sub_pulses", pulses, 0);
        check("sub_busy", busy_a, 0);
        in_energy = 0;
        step(1'b1, 1);
        check("e0_cross_busy", busy_a, 1);
        in_energy = 1000;

        // Basic peak followed by gap suppression and a second detection.
        do_reset();
        run(10, 0);
        check("basic_busy_idle", busy_a, 0);
        step(1'b1, 600);
        check("basic_busy_rise", busy_a, 1);
        step(1'b1, 700);
        run(3, 650);
        check("basic_early", det_valid_a, 0);
        step(1'b1, 650);
        check("basic_det_valid", det_valid_a, 1);
        check("basic_det_index", det_index_a, 11);
        check("basic_det_metric", det_metric_a, 700);
        check("basic_det_index_b", det_index_b, 11);
        step(1'b1, 650);
        check("basic_fall", det_valid_a, 0);
        check("basic_index_held", det_index_a, 11);
        step(1'b1, 900);
        run(5, 650);
        check("gap_busy_hold", busy_a, 1);
        step(1'b1, 650);
        check("gap_busy_fall", busy_a, 0);
        check("gap_pulses", pulses, 1);
        run(4, 900);
        check("gap2_early", det_valid_a, 0);
        step(1'b1, 900);
        check("gap2_det_valid", det_valid_a, 1);
        check("gap2_det_index", det_index_a, 24);
        check("gap2_det_metric", det_metric_a, 900);
        check("gap2_det_index_b", det_index_b, 8);
        check("gap2_pulses", pulses, 2);

        // Tie keeps the earlier sample; a later larger value restarts the hold.
        do_reset();
        run(11, 0);
        step(1'b1, 700);
        step(1'b1, 700);
        step(1'b1, 650);
        step(1'b1, 800);
        run(3, 650);
        check("tie_early", det_valid_a, 0);
        step(1'b1, 650);
        check("tie_det_valid", det_valid_a, 1);
        check("tie_det_index", det_index_a, 14);
        check("tie_det_metric", det_metric_a, 800);
        check("tie_pulses", pulses, 1);

        // Stalled stream; idle cycles carry a large metric that must be ignored.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            step(1'b1, 0);
            step(1'b0, 5000);
        end
        step(1'b1, 700);
        step(1'b0, 5000);
        for (int k = 1; k <= 3; k++) begin
            step(1'b1, 650);
            step(1'b0, 5000);
        end
        check("wrap_early", det_valid_a, 0);
        step(1'b1, 650);
        check("wrap_det_valid", det_valid_a, 1);
        check("wrap_det_index_a", det_index_a, 19);
        check("wrap_det_index_b", det_index_b, 3);
        check("wrap_det_metric_b", det_metric_b, 700);
        step(1'b0, 5000);
        check("wrap_fall", det_valid_a, 0);
        check("wrap_pulses", pulses, 1);

        // Leave the gap, enter TRACK, then reset mid-track.
        run(8, 0);
        step(1'b1, 600);
        check("mid_track_busy", busy_a, 1);
        step(1'b1, 700);
        rst = 1'b1;
        step(1'b1, 650);
        rst    = 1'b0;
        pulses = 0;
        check("mid_rst_det_valid", det_valid_a, 0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_det_index", det_index_a, 0);
        check("mid_rst_det_metric", det_metric_a, 0);
        run(4, 650);
        check("mid_rst_no_pulse", pulses, 0);
        step(1'b1, 650);
        check("mid_rst_det_valid2", det_valid_a, 1);
        check("mid_rst_det_index2", det_index_a, 0);
        check("mid_rst_det_metric2", det_metric_a, 650);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
